mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, width of every address port and of the internal address register.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets the block.
REQ-004 rdy  in  1  global enable; rdy==0 freezes all state.
REQ-005 if_req  in  1  instruction-fetch request, held until if_done or clear.
REQ-006 if_addr  in  ADDR_W  fetch byte address; always a 4-byte read.
REQ-007 if_done  out  1  one-cycle pulse marking that if_data is valid.
REQ-008 if_data  out  32  fetched word, little-endian.
REQ-009 ls_req  in  1  load/store request, held until ls_done.
REQ-010 ls_wr  in  1  1 = store, 0 = load.
REQ-011 ls_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = reserved (treated as 4).
REQ-012 ls_addr  in  ADDR_W  data byte address.
REQ-013 ls_wdata  in  32  store data; low bytes are used first.
REQ-014 ls_done  out  1  one-cycle pulse marking load data valid or store complete.
REQ-015 ls_rdata  out  32  load data, zero-extended above ls_len bytes.
REQ-016 clear  in  1  pipeline flush (branch mispredict).
REQ-017 mem_din  in  8  RAM read byte, valid one cycle after its address.
REQ-018 mem_dout  out  8  RAM write byte.
REQ-019 mem_a  out  ADDR_W  RAM byte address.
REQ-020 mem_wr  out  1  RAM write strobe, 1 = write.

Function
REQ-021 FSM states: IDLE, BUSY_IF, BUSY_LS; requests are sampled only in IDLE.
REQ-022 Grant cycle G is an IDLE cycle with a request; next state is BUSY_IF or BUSY_LS, the address is latched, and the byte counter is set to 0.
REQ-023 Tie (both requests in IDLE): grant goes to the requester not granted last; the last-grant bit resets to IF, so the first tie goes to LS.
REQ-024 A single request is granted in its grant cycle regardless of the last-grant bit.
REQ-025 N = transfer bytes: 4 for fetch, 1, 2 or 4 for LS per ls_len.
REQ-026 Read: mem_a = base+k during cycle G+1+k, for k = 0..N-1.
REQ-027 Read capture: mem_din is captured into byte k of the result at cycle G+2+k.
REQ-028 Read completion: the done pulse is asserted at cycle G+N+2 with the data valid in that same cycle.
REQ-029 Write: mem_a = base+k, mem_dout = ls_wdata[8k+7:8k] and mem_wr = 1 in cycle G+1+k.
REQ-030 Write completion: ls_done is asserted at cycle G+N+1.
REQ-031 mem_wr is 0 in every cycle not covered by REQ-029.
REQ-032 The done cycle returns the FSM to IDLE; the cycle after done is IDLE and may grant.
REQ-033 A request still asserted in the done cycle is not regranted in that cycle.
REQ-034 if_done and ls_done are never high together and are each high for exactly one cycle per grant.
REQ-035 Address arithmetic base+k wraps modulo 2^ADDR_W.
REQ-036 if_data and ls_rdata hold their value after done until the next completion of the same port.
REQ-037 clear in BUSY_IF: the fetch is aborted, the next state is IDLE, and no if_done is issued.
REQ-038 clear in IDLE with if_req: no fetch grant that cycle; an ls_req in the same cycle is still granted.
REQ-039 clear in BUSY_LS: ignored; the load or store completes normally.
REQ-040 rdy==0: state, counter, address and outputs hold; mem_wr is forced to 0 and the byte is reissued when rdy returns.

Reset
REQ-041 While rst==0 at a clock edge: state goes to IDLE, the counter to 0, and the last-grant bit to IF.
REQ-042 While rst==0 at a clock edge: if_done, ls_done, mem_wr, mem_dout, mem_a, if_data and ls_rdata all go to 0.
REQ-043 Reset has priority over rdy and clear.
REQ-044 Reset mid-transfer abandons the transfer with no done pulse.

Verification
REQ-045 Fetch only: if_req with if_addr=0x100 and RAM bytes 0x13,0x05,0x00,0x00 -> mem_a=0x100..0x103 at G+1..G+4, if_done at G+6, if_data=0x00000513.
REQ-046 Byte store: ls_wr=1, ls_len=0, ls_addr=0x2000, ls_wdata=0xAABBCCDD -> a single mem_wr at G+1 with mem_a=0x2000 and mem_dout=0xDD, ls_done at G+2.
REQ-047 Tie: both requests from reset -> LS granted first; after ls_done and one IDLE cycle, IF is granted; on a repeated tie IF is not granted twice in a row.
REQ-048 Clear: clear asserted at G+3 of a fetch -> IDLE next cycle, no if_done; a pending ls_req is granted in that IDLE cycle.
REQ-049 Stall: rdy=0 for 2 cycles during the byte 1 write of a 4-byte store -> mem_wr=0 while stalled, all bytes written exactly once, ls_done delayed by 2 cycles.
REQ-050 Reset: rst=0 at G+2 of a load -> all outputs 0, no ls_done, FSM IDLE; the request is regranted after rst=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port byte-serial memory arbiter: instruction fetch and load/store share
// one 8-bit RAM port, with round-robin tie breaking, flush and stall support.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_len,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic              clear,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } state_t;

    function automatic logic [2:0] ls_bytes(input logic [1:0] len);
        case (len)
            2'd0:    ls_bytes = 3'd1;
            2'd1:    ls_bytes = 3'd2;
            default: ls_bytes = 3'd4;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              last_ls_q, last_ls_d;
    logic [31:0]       buf_q, buf_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;

    logic              if_eff_s, grant_if_s, grant_ls_s;
    logic [ADDR_W-1:0] next_a_s;
    logic [1:0]        nxt_idx_s, rd_idx_s;
    logic [31:0]       rd_word_s;

    // Next-state, grant and byte-sequencing logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        last_ls_d  = last_ls_q;
        buf_d      = buf_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;

        // A flushed fetch must not win arbitration, but a load/store still can.
        if_eff_s   = if_req & ~clear;
        grant_ls_s = ls_req & (~if_eff_s | ~last_ls_q);
        grant_if_s = if_eff_s & ~grant_ls_s;
        next_a_s   = addr_q + ADDR_W'(cnt_q + 3'd1);
        nxt_idx_s  = 2'(cnt_q + 3'd1);
        rd_idx_s   = 2'(cnt_q - 3'd1);
        rd_word_s  = buf_q;
        rd_word_s[{rd_idx_s, 3'b000} +: 8] = mem_din;

        case (state_q)
            ST_IDLE: begin
                if (grant_ls_s) begin
                    state_d    = ST_BUSY_LS;
                    cnt_d      = 3'd0;
                    len_d      = ls_bytes(ls_len);
                    addr_d     = ls_addr;
                    wr_d       = ls_wr;
                    last_ls_d  = 1'b1;
                    buf_d      = 32'h0000_0000;
                    mem_a_d    = ls_addr;
                    mem_dout_d = ls_wdata[7:0];
                    mem_wr_d   = ls_wr;
                end else if (grant_if_s) begin
                    state_d    = ST_BUSY_IF;
                    cnt_d      = 3'd0;
                    len_d      = 3'd4;
                    addr_d     = if_addr;
                    wr_d       = 1'b0;
                    last_ls_d  = 1'b0;
                    buf_d      = 32'h0000_0000;
                    mem_a_d    = if_addr;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BUSY_IF, ST_BUSY_LS: begin
                if (state_q == ST_BUSY_IF && clear) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (wr_q) begin
                    if ((cnt_q + 3'd1) < len_q) begin
                        mem_a_d    = next_a_s;
                        mem_dout_d = ls_wdata[{nxt_idx_s, 3'b000} +: 8];
                        mem_wr_d   = 1'b1;
                    end else begin
                        mem_wr_d   = 1'b0;
                    end
                    if ((cnt_q + 3'd1) == len_q) begin
                        ls_done_d = 1'b1;
                    end else begin
                        ls_done_d = 1'b0;
                    end
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                    end
                end else begin
                    // RAM returns byte k one cycle after its address, hence the k-1 capture.
                    if (cnt_q != 3'd0 && cnt_q <= len_q) begin
                        buf_d = rd_word_s;
                    end else begin
                        buf_d = buf_q;
                    end
                    if ((cnt_q + 3'd1) < len_q) begin
                        mem_a_d = next_a_s;
                    end else begin
                        mem_a_d = mem_a_q;
                    end
                    if (cnt_q == len_q) begin
                        if (state_q == ST_BUSY_IF) begin
                            if_done_d  = 1'b1;
                            if_data_d  = rd_word_s;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = rd_word_s;
                        end
                    end else begin
                        if_done_d = 1'b0;
                    end
                    if (cnt_q == (len_q + 3'd1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and output registers; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            last_ls_q  <= 1'b0;
            buf_q      <= 32'h0000_0000;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'h0000_0000;
            ls_rdata_q <= 32'h0000_0000;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h00;
            mem_wr_q   <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            last_ls_q  <= last_ls_d;
            buf_q      <= buf_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q & rdy;

endmodule
